// File: rtl/parity_frame_gen.sv
// Streaming parity generator/checker: accumulates XOR parity over a handshaked frame
// of DATA_W-bit words and reports parity, beat count, check result and an error tally.
module parity_frame_gen #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              odd_mode,
    input  logic              chk_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              in_par,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_parity,
    output logic [CNT_W-1:0]  out_beats,
    output logic              out_err,
    output logic [CNT_W-1:0]  err_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             state;
    state_t             state_nxt;
    logic               ready_en;
    logic               acc;
    logic               mode;
    logic [CNT_W-1:0]   beats;
    logic               beat_ok;
    logic               res_take;
    logic               acc_nxt;
    logic               mode_nxt;
    logic [CNT_W-1:0]   beats_nxt;
    logic               par_nxt;

    // ready_en keeps in_ready low until the first edge after reset is released.
    assign beat_ok   = in_valid & ready_en & (state != DONE);
    assign out_valid = (state == DONE);
    assign res_take  = out_valid & out_ready;

    // A frame's first beat restarts the accumulator and latches the parity mode.
    assign acc_nxt   = ((state == IDLE) ? 1'b0 : acc) ^ (^in_data);
    assign mode_nxt  = (state == IDLE) ? odd_mode : mode;
    assign beats_nxt = (state == IDLE)     ? CNT_ONE :
                       (beats == CNT_MAX)  ? beats   : beats + 1'b1;
    assign par_nxt   = acc_nxt ^ mode_nxt;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE, ACCUM: begin
                in_ready = ready_en;
                if (beat_ok) state_nxt = in_last ? DONE : ACCUM;
            end
            DONE: begin
                if (res_take) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_en   <= 1'b0;
            acc        <= 1'b0;
            mode       <= 1'b0;
            beats      <= '0;
            out_parity <= 1'b0;
            out_beats  <= '0;
            out_err    <= 1'b0;
            err_cnt    <= '0;
        end else begin
            ready_en <= 1'b1;
            if (beat_ok) begin
                acc   <= acc_nxt;
                mode  <= mode_nxt;
                beats <= beats_nxt;
                if (in_last) begin
                    // chk_en gates in_par so an undriven parity bit never reaches out_err.
                    out_parity <= par_nxt;
                    out_beats  <= beats_nxt;
                    out_err    <= chk_en & (par_nxt ^ in_par);
                end
            end
            if (res_take && out_err && (err_cnt != CNT_MAX))
                err_cnt <= err_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_parity_frame_gen.sv
// Self-checking bench for parity_frame_gen: directed cases plus random frames
// compared against a ones-counting reference model.
module tb_parity_frame_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        odd_mode;
    logic        chk_en;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        in_par;
    logic        out_valid;
    logic        out_ready;
    logic        out_parity;
    logic [15:0] out_beats;
    logic        out_err;
    logic [15:0] err_cnt;

    int checks = 0;
    int errors = 0;

    logic [7:0] frame_q[$];
    int         exp_errcnt = 0;
    bit         exp_err_last;
    bit         exp_par_last;
    int         exp_beats_last;

    always #5 clk = ~clk;

    parity_frame_gen #(.DATA_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .odd_mode(odd_mode), .chk_en(chk_en),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .in_par(in_par), .out_valid(out_valid),
        .out_ready(out_ready), .out_parity(out_parity), .out_beats(out_beats),
        .out_err(out_err), .err_cnt(err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: parity of total ones in the frame, inverted for odd mode.
    function automatic bit model_parity(input bit odd);
        int ones = 0;
        foreach (frame_q[i]) ones += $countones(frame_q[i]);
        return bit'(ones % 2) ^ odd;
    endfunction

    // Present one word at a negedge and return after the edge that accepts it.
    task automatic send_beat(input logic [7:0] d, input bit last);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_timeout", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
    endtask

    // Send frame_q, toggling odd_mode after beat 0 if asked, then check the result.
    task automatic run_frame(input bit odd, input bit chk, input bit par,
                             input bit toggle, input bit gaps, input string tag);
        for (int i = 0; i < frame_q.size(); i++) begin
            @(negedge clk);
            if (gaps && i > 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            odd_mode = (i == 0) ? odd : (toggle ? ~odd : odd);
            if (i == frame_q.size() - 1) begin
                chk_en = chk;
                in_par = chk ? par : 1'bx;
            end else begin
                chk_en = 1'($urandom);
                in_par = 1'($urandom);
            end
            send_beat(frame_q[i], i == frame_q.size() - 1);
        end
        @(negedge clk);
        in_valid       = 1'b0;
        odd_mode       = ~odd;
        exp_par_last   = model_parity(odd);
        exp_beats_last = frame_q.size();
        exp_err_last   = chk && (exp_par_last != par);
        check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_parity"}, {31'b0, out_parity}, {31'b0, exp_par_last});
        check({tag, "_beats"}, {16'b0, out_beats}, exp_beats_last);
        check({tag, "_err"}, {31'b0, out_err}, {31'b0, exp_err_last});
        check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        if (exp_err_last) exp_errcnt++;
        check({tag, "_vld_drop"}, {31'b0, out_valid}, 32'd0);
        check({tag, "_errcnt"}, {16'b0, err_cnt}, exp_errcnt);
    endtask

    task automatic single(input logic [7:0] d, input bit odd, input bit chk,
                          input bit par, input string tag);
        frame_q = '{d};
        run_frame(odd, chk, par, 1'b0, 1'b0, tag);
        consume(tag);
    endtask

    initial begin
        rst = 1'b1; odd_mode = 1'b0; chk_en = 1'b0; in_valid = 1'b0;
        in_data = '0; in_last = 1'b0; in_par = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_err_cnt", {16'b0, err_cnt}, 32'd0);
        check("rst_out_beats", {16'b0, out_beats}, 32'd0);
        rst = 1'b0;
        check("rst_release_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        check("post_rst_ready", {31'b0, in_ready}, 32'd1);

        single(8'hA5, 1'b0, 1'b0, 1'b0, "even_a5");
        single(8'hA5, 1'b1, 1'b0, 1'b0, "odd_a5");
        single(8'h00, 1'b1, 1'b0, 1'b0, "odd_00");
        single(8'h01, 1'b0, 1'b0, 1'b0, "even_01");

        frame_q = '{8'h01, 8'h03, 8'h07};
        run_frame(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "multi");
        consume("multi");

        single(8'h80, 1'b0, 1'b1, 1'b0, "chk_bad");
        single(8'h80, 1'b0, 1'b1, 1'b1, "chk_good");

        // Backpressure: result held while a new word waits at the input.
        frame_q = '{8'h3C, 8'h01};
        run_frame(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "bp");
        in_valid = 1'b1; in_data = 8'hFF; in_last = 1'b1;
        odd_mode = 1'b0; chk_en = 1'b0; in_par = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
            check("bp_hold_parity", {31'b0, out_parity}, {31'b0, exp_par_last});
            check("bp_hold_beats", {16'b0, out_beats}, exp_beats_last);
            check("bp_hold_err", {31'b0, out_err}, {31'b0, exp_err_last});
            check("bp_hold_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        if (exp_err_last) exp_errcnt++;
        check("bp_after_hs_valid", {31'b0, out_valid}, 32'd0);
        check("bp_after_hs_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_ff_valid", {31'b0, out_valid}, 32'd1);
        check("bp_ff_parity", {31'b0, out_parity}, 32'd0);
        check("bp_ff_beats", {16'b0, out_beats}, 32'd1);
        exp_err_last = 1'b0;
        consume("bp_ff");

        // Reset in the middle of a frame.
        frame_q = '{8'h11, 8'h22};
        @(negedge clk);
        odd_mode = 1'b1;
        send_beat(8'h11, 1'b0);
        @(negedge clk);
        send_beat(8'h22, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_errcnt = 0;
        check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_parity", {31'b0, out_parity}, 32'd0);
        check("mid_rst_beats", {16'b0, out_beats}, 32'd0);
        check("mid_rst_err", {31'b0, out_err}, 32'd0);
        check("mid_rst_errcnt", {16'b0, err_cnt}, 32'd0);
        check("mid_rst_ready", {31'b0, in_ready}, 32'd0);
        single(8'h03, 1'b0, 1'b0, 1'b0, "post_rst");

        for (int f = 0; f < 30; f++) begin
            int len = $urandom_range(1, 6);
            frame_q = {};
            for (int b = 0; b < len; b++) frame_q.push_back(8'($urandom));
            run_frame(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1, "rand");
            repeat ($urandom_range(0, 3)) @(negedge clk);
            consume("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
